stream_mux_2x1: RTL and testbench

STREAM_MUX_2X1 -- requirements
Module: stream_mux_2x1

---
 rtl/stream_mux_2x1.sv | 102 ++++++++++
 tb/tb_stream_mux_2x1.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_2x1.sv
// rtl/stream_mux_2x1.sv - 2:1 stream merge into a 2-entry {sel,data} FIFO; STREAM_MUX_RR_EN selects round-robin arbitration
module stream_mux_2x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i0_data,
  input  logic             i0_valid,
  output logic             i0_ready,
  input  logic [WIDTH-1:0] i1_data,
  input  logic             i1_valid,
  output logic             i1_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_sel,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t         state, state_nx;
  logic [WIDTH:0] head, tail;        // {sel,data}; head is the oldest entry
  logic           last_sel, last_sel_nx;
  logic           rdy0_q, rdy1_q;
  logic           acc0, acc1, accept, pop;
  logic [WIDTH:0] in_entry;
  logic           gnt_valid, gnt_sel;

  assign acc0     = i0_valid && rdy0_q;
  assign acc1     = i1_valid && rdy1_q;
  assign accept   = acc0 || acc1;
  assign pop      = (state != EMPTY) && y_ready;
  assign in_entry = acc1 ? {1'b1, i1_data} : {1'b0, i0_data};

  // Readies come from registers; rst_n masks them so no handshake completes in a reset cycle
  assign i0_ready = rdy0_q && rst_n;
  assign i1_ready = rdy1_q && rst_n;
  assign y_valid  = (state != EMPTY) && rst_n;
  assign y_data   = head[WIDTH-1:0];
  assign y_sel    = head[WIDTH];

  // Occupancy transition and post-accept arbitration history
  always_comb begin
    state_nx    = state;
    last_sel_nx = accept ? acc1 : last_sel;
    case (state)
      EMPTY:   if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !pop)      state_nx = FULL;
        else if (pop && !accept) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  // Grant for the next cycle, decided from this cycle's valids and the updated history
  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = 1'b0;
    if (i0_valid && i1_valid) begin
      gnt_valid = 1'b1;
`ifdef STREAM_MUX_RR_EN
      gnt_sel   = ~last_sel_nx;
`else
      gnt_sel   = 1'b0;
`endif
    end else if (i0_valid) begin
      gnt_valid = 1'b1;
    end else if (i1_valid) begin
      gnt_valid = 1'b1;
      gnt_sel   = 1'b1;
    end
  end

  // FIFO storage, occupancy, history and registered readiness
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      head     <= '0;
      tail     <= '0;
      last_sel <= 1'b1;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      last_sel <= last_sel_nx;
      rdy0_q   <= (state_nx != FULL) && gnt_valid && !gnt_sel;
      rdy1_q   <= (state_nx != FULL) && gnt_valid && gnt_sel;
      case (state)
        EMPTY:   if (accept) head <= in_entry;
        ONE: begin
          if (accept && pop) head <= in_entry;
          else if (accept)   tail <= in_entry;
        end
        FULL:    if (pop) head <= tail;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_mux_2x1.sv
// tb/tb_stream_mux_2x1.sv - self-checking bench for stream_mux_2x1 against a queue-based model
module tb_stream_mux_2x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i0_data, i1_data, y_data;
  logic       i0_valid, i1_valid, i0_ready, i1_ready;
  logic       y_sel, y_valid, y_ready;

  int checks = 0;
  int failures = 0;

  bit [7:0] src0[$], src1[$];
  bit       en0, en1;
  bit [8:0] mq[$];
  bit       m_last, m_r0, m_r1;
  bit [8:0] out_log[$];
  int       out_cyc[$];
  bit [7:0] sent0[$], sent1[$];
  int       cyc = 0;
  int       nacc0 = 0, nacc1 = 0;
  int       dut_acc0 = 0;

  always #5 clk = ~clk;

  stream_mux_2x1 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i0_data(i0_data), .i0_valid(i0_valid), .i0_ready(i0_ready),
    .i1_data(i1_data), .i1_valid(i1_valid), .i1_ready(i1_ready),
    .y_data(y_data), .y_sel(y_sel), .y_valid(y_valid), .y_ready(y_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    i0_valid = en0 && (src0.size() != 0);
    i0_data  = (src0.size() != 0) ? src0[0] : 8'h00;
    i1_valid = en1 && (src1.size() != 0);
    i1_data  = (src1.size() != 0) ? src1[0] : 8'h00;
  endtask

  task automatic expect_log(input string tag, input bit [8:0] exp[$]);
    chk({tag, "_count"}, out_log.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < out_log.size()) ? out_log[i] : 9'h1FF, exp[i]);
  endtask

  // One clock: compare outputs on the falling edge, advance the model on the rising edge
  task automatic cycle();
    bit [8:0] h;
    bit       a0, a1, gv, gs;
    @(negedge clk);
    chk("y_valid", y_valid, rst_n && (mq.size() != 0));
    chk("i0_ready", i0_ready, rst_n && m_r0);
    chk("i1_ready", i1_ready, rst_n && m_r1);
    if (rst_n && mq.size() != 0) begin
      h = mq[0];
      chk("y_data", y_data, h[7:0]);
      chk("y_sel", y_sel, h[8]);
    end
    if (y_valid && y_ready) begin
      out_log.push_back({y_sel, y_data});
      out_cyc.push_back(cyc);
    end
    if (i0_valid && i0_ready) dut_acc0++;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      m_last = 1'b1;
      m_r0 = 1'b0;
      m_r1 = 1'b0;
    end else begin
      a0 = i0_valid && m_r0;
      a1 = i1_valid && m_r1;
      if (mq.size() != 0 && y_ready) void'(mq.pop_front());
      if (a0) begin
        mq.push_back({1'b0, i0_data}); sent0.push_back(i0_data);
        void'(src0.pop_front()); nacc0++; m_last = 1'b0;
      end
      if (a1) begin
        mq.push_back({1'b1, i1_data}); sent1.push_back(i1_data);
        void'(src1.pop_front()); nacc1++; m_last = 1'b1;
      end
      gv = i0_valid || i1_valid;
`ifdef STREAM_MUX_RR_EN
      gs = (i0_valid && i1_valid) ? !m_last : !i0_valid;
`else
      gs = !i0_valid;
`endif
      m_r0 = (mq.size() < 2) && gv && !gs;
      m_r1 = (mq.size() < 2) && gv && gs;
    end
    #1;
    drive();
  endtask

  initial begin
    bit [8:0] exp_q[$];
    int       k0, k1;
    bit [8:0] e;

    // Reset held 3 cycles with both channels valid
    rst_n = 1'b0; y_ready = 1'b1; en0 = 1'b1; en1 = 1'b1;
    m_last = 1'b1; m_r0 = 1'b0; m_r1 = 1'b0;
    src0.push_back(8'h5A); src1.push_back(8'hC3);
    drive();
    repeat (3) cycle();
    chk("rst_y_data", y_data, 8'h00);
    chk("rst_y_sel", y_sel, 1'b0);
    chk("rst_no_accept", nacc0 + nacc1, 0);
    rst_n = 1'b1;
    repeat (6) cycle();
    chk("first_out_ch0", (out_log.size() != 0) ? out_log[0] : 9'h1FF, 9'h05A);

    // Channel 1 alone, back-to-back
    out_log.delete(); out_cyc.delete();
    en0 = 1'b0; en1 = 1'b1;
    src1 = '{8'h11, 8'h22, 8'h33};
    drive();
    repeat (8) cycle();
    exp_q = '{9'h111, 9'h122, 9'h133};
    expect_log("single", exp_q);
    chk("single_consec1", (out_cyc.size() > 1) ? out_cyc[1] - out_cyc[0] : -1, 1);
    chk("single_consec2", (out_cyc.size() > 2) ? out_cyc[2] - out_cyc[1] : -1, 1);

    // Tie: both channels continuously valid
    out_log.delete();
    en0 = 1'b1; en1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src0.push_back(8'hA0 + 8'(i));
      src1.push_back(8'hB0 + 8'(i));
    end
    drive();
    repeat (8) cycle();
`ifdef STREAM_MUX_RR_EN
    exp_q = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1};
`else
    exp_q = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3};
    chk("tie_i1_starved", src1.size(), 8);
`endif
    for (int i = 0; i < 4; i++)
      chk("tie_order", (i < out_log.size()) ? out_log[i] : 9'h1FF, exp_q[i]);
    en0 = 1'b0; en1 = 1'b0; src0.delete(); src1.delete();
    drive();
    repeat (4) cycle();

    // Backpressure: downstream stalled, channel 0 streaming
    out_log.delete(); dut_acc0 = 0;
    y_ready = 1'b0; en0 = 1'b1;
    src0 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    drive();
    repeat (6) cycle();
    chk("bp_accepted", dut_acc0, 2);
    chk("bp_i0_ready", i0_ready, 1'b0);
    chk("bp_y_data_held", y_data, 8'hC1);
    src0.delete(); drive();
    y_ready = 1'b1;
    repeat (4) cycle();
    exp_q = '{9'h0C1, 9'h0C2};
    expect_log("bp_drain", exp_q);

    // Reset while FULL
    out_log.delete();
    y_ready = 1'b0;
    src0 = '{8'hD1, 8'hD2, 8'hD3};
    drive();
    repeat (5) cycle();
    chk("mr_full_valid", y_valid, 1'b1);
    chk("mr_full_ready", i0_ready, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; src0.delete(); y_ready = 1'b1;
    drive();
    chk("mr_valid_after", y_valid, 1'b0);
    repeat (4) cycle();
    chk("mr_no_leak", out_log.size(), 0);

    // Random traffic against the model
    out_log.delete(); sent0.delete(); sent1.delete();
    nacc0 = 0; nacc1 = 0;
    for (int n = 0; n < 300; n++) begin
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      y_ready = ($urandom_range(0, 3) != 0);
      if (src0.size() < 2) src0.push_back(8'($urandom));
      if (src1.size() < 2) src1.push_back(8'($urandom));
      drive();
      cycle();
    end
    en0 = 1'b0; en1 = 1'b0; y_ready = 1'b1;
    drive();
    repeat (5) cycle();
    chk("rand_drained", y_valid, 1'b0);
    chk("rand_count", out_log.size(), nacc0 + nacc1);
    k0 = 0; k1 = 0;
    for (int i = 0; i < out_log.size(); i++) begin
      e = out_log[i];
      if (e[8]) begin
        chk("rand_order_ch1", e[7:0], (k1 < sent1.size()) ? sent1[k1] : 8'h00);
        k1++;
      end else begin
        chk("rand_order_ch0", e[7:0], (k0 < sent0.size()) ? sent0[k0] : 8'h00);
        k0++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
